// File: rtl/up_down_counter_async.sv
// Free-running 4-bit up/down counter with an asynchronous active-high clear.
// The count is also shown as two active-low 7-segment digits (tens, ones).
module up_down_counter_async (
    input  logic       clk,
    input  logic       reset,
    input  logic       mode,
    output logic [3:0] q,
    output logic [7:0] ones,
    output logic [7:0] tens
);

    // Segment patterns: bit7=a .. bit1=g, bit0=dp; low lights a segment.
    localparam logic [7:0] SEG_0     = 8'h03;
    localparam logic [7:0] SEG_1     = 8'h9F;
    localparam logic [7:0] SEG_2     = 8'h25;
    localparam logic [7:0] SEG_3     = 8'h0D;
    localparam logic [7:0] SEG_4     = 8'h99;
    localparam logic [7:0] SEG_5     = 8'h49;
    localparam logic [7:0] SEG_6     = 8'h41;
    localparam logic [7:0] SEG_7     = 8'h1F;
    localparam logic [7:0] SEG_8     = 8'h01;
    localparam logic [7:0] SEG_9     = 8'h09;
    localparam logic [7:0] SEG_BLANK = 8'hFF;

    logic [3:0] r_q;
    logic [3:0] w_q_next;
    logic [7:0] w_ones;
    logic [7:0] w_tens;

    // Natural 4-bit wrap gives 15->0 going up and 0->15 going down.
    assign w_q_next = mode ? (r_q + 4'd1) : (r_q - 4'd1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_q <= 4'd0;
        end else begin
            r_q <= w_q_next;
        end
    end

    // Decoded straight from the register so the display tracks q with no delay.
    // An unknown count falls through to default and blanks both digits.
    always_comb begin
        w_ones = SEG_BLANK;
        w_tens = SEG_BLANK;
        case (r_q)
            4'd0:  w_ones = SEG_0;
            4'd1:  w_ones = SEG_1;
            4'd2:  w_ones = SEG_2;
            4'd3:  w_ones = SEG_3;
            4'd4:  w_ones = SEG_4;
            4'd5:  w_ones = SEG_5;
            4'd6:  w_ones = SEG_6;
            4'd7:  w_ones = SEG_7;
            4'd8:  w_ones = SEG_8;
            4'd9:  w_ones = SEG_9;
            4'd10: begin w_ones = SEG_0; w_tens = SEG_1; end
            4'd11: begin w_ones = SEG_1; w_tens = SEG_1; end
            4'd12: begin w_ones = SEG_2; w_tens = SEG_1; end
            4'd13: begin w_ones = SEG_3; w_tens = SEG_1; end
            4'd14: begin w_ones = SEG_4; w_tens = SEG_1; end
            4'd15: begin w_ones = SEG_5; w_tens = SEG_1; end
            default: begin
                w_ones = SEG_BLANK;
                w_tens = SEG_BLANK;
            end
        endcase
    end

    assign q    = r_q;
    assign ones = w_ones;
    assign tens = w_tens;

endmodule

// File: tb/tb_up_down_counter_async.sv
// Directed bench for up_down_counter_async: reset, down/up sweeps, wraps,
// direction change and asynchronous clear, each checked by immediate assertions.
module tb_up_down_counter_async;

    logic       clk;
    logic       reset;
    logic       mode;
    logic [3:0] q;
    logic [7:0] ones;
    logic [7:0] tens;

    int n_checks;
    int n_errors;

    up_down_counter_async dut (
        .clk   (clk),
        .reset (reset),
        .mode  (mode),
        .q     (q),
        .ones  (ones),
        .tens  (tens)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] digit_seg(input int d);
        case (d)
            0: return 8'h03;
            1: return 8'h9F;
            2: return 8'h25;
            3: return 8'h0D;
            4: return 8'h99;
            5: return 8'h49;
            6: return 8'h41;
            7: return 8'h1F;
            8: return 8'h01;
            9: return 8'h09;
            default: return 8'hFF;
        endcase
    endfunction

    task automatic check3(input string tag, input logic [3:0] eq,
                          input logic [7:0] eo, input logic [7:0] et);
        n_checks++;
        assert (q === eq) else begin
            n_errors++;
            $error("FAIL %s q: got %0h expected %0h", tag, q, eq);
        end
        n_checks++;
        assert (ones === eo) else begin
            n_errors++;
            $error("FAIL %s ones: got %02h expected %02h", tag, ones, eo);
        end
        n_checks++;
        assert (tens === et) else begin
            n_errors++;
            $error("FAIL %s tens: got %02h expected %02h", tag, tens, et);
        end
    endtask

    task automatic check_q(input string tag, input int v);
        check3(tag, 4'(v), digit_seg(v % 10), (v >= 10) ? 8'h9F : 8'hFF);
    endtask

    task automatic edge_check(input string tag, input int v);
        @(posedge clk);
        #1;
        check_q(tag, v);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        reset = 1'b1;
        mode  = 1'b0;
        #1;
        check3("reset_t0", 4'd0, 8'h03, 8'hFF);

        // Held reset with mode=0: no counting across 16 edges.
        for (int i = 0; i < 16; i++) begin
            @(posedge clk);
            #1;
            check3("reset_hold", 4'd0, 8'h03, 8'hFF);
        end

        @(negedge clk);
        reset = 1'b0;
        #1;
        check3("release_no_step", 4'd0, 8'h03, 8'hFF);

        // Down count from 0: 15, 14, ... 0.
        edge_check("down_e1", 15);
        check3("down_e1_lit", 4'd15, 8'h49, 8'h9F);
        edge_check("down_e2", 14);
        check3("down_e2_lit", 4'd14, 8'h99, 8'h9F);
        for (int i = 3; i <= 16; i++) edge_check("down_seq", 16 - i);
        check3("down_e16_lit", 4'd0, 8'h03, 8'hFF);

        // Up to 8, then through 9..15 and wrap to 0.
        mode = 1'b1;
        for (int v = 1; v <= 8; v++) edge_check("up_to8", v);
        edge_check("up_9", 9);
        check3("up_9_lit", 4'd9, 8'h09, 8'hFF);
        edge_check("up_10", 10);
        check3("up_10_lit", 4'd10, 8'h03, 8'h9F);
        edge_check("up_11", 11);
        check3("up_11_lit", 4'd11, 8'h9F, 8'h9F);
        for (int v = 12; v <= 15; v++) edge_check("up_seq", v);
        check3("up_15_lit", 4'd15, 8'h49, 8'h9F);
        edge_check("up_wrap", 0);
        check3("up_wrap_lit", 4'd0, 8'h03, 8'hFF);

        // Direction change at 5: next edge is 4, no hold.
        for (int v = 1; v <= 5; v++) edge_check("up_to5", v);
        mode = 1'b0;
        edge_check("dir_change", 4);
        check3("dir_change_lit", 4'd4, 8'h99, 8'hFF);
        edge_check("dir_after", 3);

        // Climb to 12, then clear between edges.
        mode = 1'b1;
        for (int v = 4; v <= 12; v++) edge_check("up_to12", v);
        #2;
        reset = 1'b1;
        #1;
        check3("async_clear", 4'd0, 8'h03, 8'hFF);
        @(posedge clk);
        #1;
        check3("reset_dominates_up", 4'd0, 8'h03, 8'hFF);

        @(negedge clk);
        reset = 1'b0;
        #1;
        check3("release2_no_step", 4'd0, 8'h03, 8'hFF);
        edge_check("first_up_step", 1);

        // Full up sweep, every display value checked as q changes.
        for (int v = 2; v <= 15; v++) edge_check("exh_up", v);
        edge_check("exh_wrap", 0);
        edge_check("exh_one", 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/up_down_counter_async.md
UP_DOWN_COUNTER_ASYNC -- requirements
Module: up_down_counter_async

Interface
REQ-001 Parameters SHALL be none; all widths are fixed.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  reset, asynchronous, active-high.
REQ-004 mode  input  1  count direction (1 = up, 0 = down), sampled at rising clk.
REQ-005 q  output  4  current unsigned counter value, 0..15, registered.
REQ-006 ones  output  8  active-low 7-segment pattern for the units digit of q.
REQ-007 tens  output  8  active-low 7-segment pattern for the tens digit of q.

Function
REQ-008 Segment bit mapping SHALL be bit7=a, bit6=b, bit5=c, bit4=d, bit3=e, bit2=f, bit1=g, bit0=dp; 0 = segment lit; dp always 1 (off).
REQ-009 At each rising clk with reset low, mode=1 SHALL set q <= q+1 modulo 16 (15 -> 0 wrap).
REQ-010 At each rising clk with reset low, mode=0 SHALL set q <= q-1 modulo 16 (0 -> 15 wrap).
REQ-011 Counter SHALL never hold; exactly one step per clock edge while reset is low.
REQ-012 mode change SHALL take effect on the next rising clk, with no extra latency or skipped count.
REQ-013 ones/tens SHALL be purely combinational from q, with zero-cycle latency: they update in the same delta as q.
REQ-014 Digit encodings SHALL be: 0=03, 1=9F, 2=25, 3=0D, 4=99, 5=49, 6=41, 7=1F, 8=01, 9=09 (hex).
REQ-015 For q=0..9: ones = digit(q), tens = FF (blank).
REQ-016 For q=10..15: ones = digit(q-10), tens = 9F ("1").
REQ-017 If q is unknown/non-decodable, ones and tens SHALL both be FF (all segments off).
REQ-018 No other outputs, flags or carry/borrow signals SHALL exist.

Reset
REQ-019 reset high SHALL force q = 0 immediately, independent of clk.
REQ-020 Consequently, during reset, ones = 03 and tens = FF.
REQ-021 reset SHALL dominate mode and clk for as long as it is high.
REQ-022 When reset goes low, q stays 0 until the next rising clk; the first count step occurs at that edge.
REQ-023 Reset asserted mid-count SHALL clear q without waiting for a clock edge.

Verification
REQ-024 reset=1, mode=0, 16 clocks -> q=0, ones=03, tens=FF throughout; no counting.
REQ-025 Release reset with mode=0 -> edge1: q=15, ones=49, tens=9F; edge2: q=14, ones=99, tens=9F; ...; edge16: q=0, ones=03, tens=FF.
REQ-026 mode=1 from q=8 -> edge sequence q=9 (ones=09, tens=FF), 10 (03/9F), 11 (9F/9F); continue to 15 (49/9F), then wrap to 0 (03/FF).
REQ-027 Switch mode 1->0 at q=5 -> next edge q=4 (ones=99, tens=FF); no hold cycle occurs.
REQ-028 Assert reset between clock edges at q=12 -> q=0, ones=03, tens=FF before the next rising clk.
REQ-029 Exhaustive up count 0..15 -> ones/tens match REQ-014..016 for every q value, checked in the same timestep q changes.
